mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multicycle MIPS control unit and the successor to the fixed-timing Control block.
- Drives every datapath select and enable for the PC, InstMem/DataMem, the IR, the A/B/ALUOut registers and RegFile.
- Adds memory wait-state handling through a `mem_ready` handshake, a parametrised bus timeout, illegal-opcode trapping and a HALT instruction.
- Sits between the IR opcode field and the multicycle datapath.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent in one memory wait state before a bus error (legal range 2..255).
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.
- HALT_OP, 6'b111111: opcode decoded as HALT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load when `zero`=1
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  writeback select: 1 = MDR
- reg_dst  out  1  destination select: 1 = rd, 0 = rt
- reg_write  out  1  RegFile write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- state  out  4  current state code
- bus_err  out  1  sticky; set on memory timeout
- illegal_op  out  1  sticky; set on undecodable opcode
- halted  out  1  high while in HALT

Behaviour:
- Moore machine; all outputs are decoded from registered state, except the wait-state strobes noted below.
- Reset (`rst`=0, asynchronous):
  - state = FETCH, wait counter = 0, `bus_err`/`illegal_op`/`halted` = 0.
  - While reset is low, all enables are forced to 0 (including `mem_read`).
  - Reset mid-access abandons the access; no write completes.
- State codes and outputs (enables not listed are 0; selects not listed are don't-care, driven 0):
  - FETCH 0: `mem_read`, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00. `ir_write` and `pc_write` are high only in a cycle where `mem_ready`=1.
  - DECODE 1: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00.
  - MEMADR 2: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - MEMRD 3: `mem_read`, `i_or_d`=1.
  - MEMWB 4: `reg_write`, `mem_to_reg`=1, `reg_dst`=0.
  - MEMWR 5: `mem_write`, `i_or_d`=1.
  - EXEC 6: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
  - RWB 7: `reg_write`, `reg_dst`=1, `mem_to_reg`=0.
  - BRANCH 8: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`, `pc_source`=01.
  - JUMP 9: `pc_write`, `pc_source`=10.
  - IEXEC 10: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - IWB 11: `reg_write`, `reg_dst`=0, `mem_to_reg`=0.
  - HALT 12: `halted`=1.
  - ERROR 13: all enables 0.
- Transitions:
  - FETCH → DECODE on `mem_ready`, else stay.
  - DECODE dispatch on `opcode`:
    - 000000 → EXEC
    - 100011 or 101011 → MEMADR
    - 000100 → BRANCH
    - 000010 → JUMP
    - 001000 → IEXEC
    - HALT_OP → HALT
    - any other opcode → ERROR, setting `illegal_op`.
  - MEMADR → MEMRD for lw, MEMWR for sw; the opcode is held stable by the IR.
  - MEMRD → MEMWB on `mem_ready`, else stay.
  - MEMWR → FETCH on `mem_ready`, else stay. `mem_write` stays high for every cycle until ready.
  - MEMWB, RWB, IWB, BRANCH, JUMP → FETCH.
  - EXEC → RWB; IEXEC → IWB.
  - HALT and ERROR are exited only by reset.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR, and whenever `mem_ready`=1.
  - Increments on each cycle spent in one of those states with `mem_ready`=0.
  - When the counter = MEM_TIMEOUT-1 and `mem_ready`=0: next state = ERROR and `bus_err` is set.
  - `mem_ready`=1 in that same cycle wins: normal transition, no error.
  - Saturates; never wraps.
- Latency with zero wait states (`mem_ready` tied high):
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, j: 3 cycles.
- Each wait cycle adds exactly 1 cycle to the instruction.

Test Plan:
- `mem_ready`=1, opcode 000000 → state sequence 0,1,6,7,0; `reg_write`=1 only in RWB with `reg_dst`=1.
- lw (100011) with `mem_ready` low for 3 cycles in MEMRD → state 3 held for 4 cycles; `mem_read`/`i_or_d`=1 throughout; then MEMWB with `mem_to_reg`=1.
- FETCH with `mem_ready` stuck 0, MEM_TIMEOUT=16 → ERROR after 16 cycles in FETCH, `bus_err`=1, `ir_write` never 1; a second run asserts `mem_ready` on the 16th cycle → DECODE, `bus_err`=0.
- opcode 010101 → ERROR after DECODE, `illegal_op`=1, all enables 0 until `rst` is pulsed low, then state=0 and flags cleared.
- beq with `zero`=1 versus `zero`=0 → `pc_write_cond`=1 and `pc_source`=01 in state 8 in both runs; opcode 111111 → `halted`=1 held over 50 cycles.
- `rst` driven low mid-MEMWR between clock edges → `mem_write` drops immediately, state=0 asynchronously.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control unit: Moore FSM that sequences the datapath
// selects/enables per instruction class, with mem_ready wait states, a bus
// timeout, illegal-opcode trapping and a HALT instruction.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8,
  parameter logic [5:0]  HALT_OP     = 6'b111111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       bus_err,
  output logic       illegal_op,
  output logic       halted
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB   = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB   = 4'd11,
    S_HALT   = 4'd12, S_ERROR  = 4'd13
  } state_t;

  // Registered control word; 'fetch' qualifies the mem_ready-gated strobes.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       fetch;
    logic       halted;
  } ctrl_t;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.fetch = 1'b1; end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_MEMRD:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:  begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
      S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      S_RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01;
        c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
      end
      S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
      S_IEXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      S_IWB:    c.reg_write = 1'b1;
      S_HALT:   c.halted = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             bus_err_reg, bus_err_next;
  logic             illegal_op_reg, illegal_op_next;
  ctrl_t            ctrl_reg;
  logic             wait_state;

  // The ALU zero flag is consumed by the datapath's PC-write gate, not here.
  logic unused_zero;
  assign unused_zero = zero;

  assign wait_state = (state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                      (state_reg == S_MEMWR);

  // Next-state, wait-counter and sticky-flag logic.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = '0;
    bus_err_next    = bus_err_reg;
    illegal_op_next = illegal_op_reg;
    case (state_reg)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_RTYPE)                       state_next = S_EXEC;
        else if (opcode == OP_LW || opcode == OP_SW)  state_next = S_MEMADR;
        else if (opcode == OP_BEQ)                    state_next = S_BRANCH;
        else if (opcode == OP_J)                      state_next = S_JUMP;
        else if (opcode == OP_ADDI)                   state_next = S_IEXEC;
        else if (opcode == HALT_OP)                   state_next = S_HALT;
        else begin
          state_next      = S_ERROR;
          illegal_op_next = 1'b1;
        end
      end
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_EXEC:   state_next = S_RWB;
      S_IEXEC:  state_next = S_IWB;
      S_HALT:   state_next = S_HALT;
      S_ERROR:  state_next = S_ERROR;
      default:  state_next = S_ERROR;
    endcase
    // A stalled memory access counts cycles; mem_ready in the last cycle wins.
    if (wait_state && !mem_ready) begin
      if (cnt_reg == CNT_LAST) begin
        state_next   = S_ERROR;
        bus_err_next = 1'b1;
      end else begin
        cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
      end
    end
  end

  // State, counter, flags and the registered control word for the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_FETCH;
      cnt_reg        <= '0;
      bus_err_reg    <= 1'b0;
      illegal_op_reg <= 1'b0;
      ctrl_reg       <= decode(S_FETCH);
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bus_err_reg    <= bus_err_next;
      illegal_op_reg <= illegal_op_next;
      ctrl_reg       <= decode(state_next);
    end
  end

  // Enables are squashed while reset is held so an in-flight access is dropped.
  assign pc_write      = rst & (ctrl_reg.pc_write | (ctrl_reg.fetch & mem_ready));
  assign ir_write      = rst & ctrl_reg.fetch & mem_ready;
  assign pc_write_cond = rst & ctrl_reg.pc_write_cond;
  assign mem_read      = rst & ctrl_reg.mem_read;
  assign mem_write     = rst & ctrl_reg.mem_write;
  assign reg_write     = rst & ctrl_reg.reg_write;
  assign i_or_d        = ctrl_reg.i_or_d;
  assign mem_to_reg    = ctrl_reg.mem_to_reg;
  assign reg_dst       = ctrl_reg.reg_dst;
  assign alu_src_a     = ctrl_reg.alu_src_a;
  assign alu_src_b     = ctrl_reg.alu_src_b;
  assign alu_op        = ctrl_reg.alu_op;
  assign pc_source     = ctrl_reg.pc_source;
  assign halted        = ctrl_reg.halted;
  assign state         = state_reg;
  assign bus_err       = bus_err_reg;
  assign illegal_op    = illegal_op_reg;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: instruction table, directed wait/timeout,
// trap, halt and async-reset sequences, plus random mem_ready against a
// path-based instruction model.
module tb_mc_ctrl_fsm;

  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       bus_err, illegal_op, halted;

  mc_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8), .HALT_OP(6'b111111)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .bus_err(bus_err),
    .illegal_op(illegal_op), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] act_out;
  assign act_out = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_source, halted};

  // Expected outputs per state, straight from the state/output table.
  function automatic logic [16:0] exp_out(input int st, input logic rdy);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    logic m2r = 0, rdst = 0, rw = 0, asa = 0, hlt = 0;
    logic [1:0] asb = 0, aop = 0, psrc = 0;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      9:  begin pcw = 1; psrc = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      12: hlt = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, hlt};
  endfunction

  task automatic chk_all(input string name, input int exp_st, input logic rdy,
                         input logic exp_bus, input logic exp_ill);
    logic [16:0] e;
    e = exp_out(exp_st, rdy);
    n_checks++;
    if (state !== 4'(exp_st) || act_out !== e || bus_err !== exp_bus ||
        illegal_op !== exp_ill) begin
      n_fail++;
      $display("FAIL %s: state=%0d outs=%h bus_err=%b illegal_op=%b, expected state=%0d outs=%h bus_err=%b illegal_op=%b",
               name, state, act_out, bus_err, illegal_op, exp_st, e, exp_bus, exp_ill);
    end
  endtask

  task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Assert reset (mem_ready high to prove the strobes are squashed), check, release.
  task automatic do_reset;
    rst = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'd0;
    @(posedge clk);
    #2;
    chk1("rst_enables", 32'({pc_write, pc_write_cond, mem_read, mem_write, ir_write,
                             reg_write, halted}), 32'd0);
    chk1("rst_state", 32'(state), 32'd0);
    chk1("rst_flags", 32'({bus_err, illegal_op}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    int         len;
    int         st[5];
  } vec_t;

  vec_t tab[6];

  task automatic set_vec(input int i, input string nm, input logic [5:0] op, input int len,
                         input int s0, input int s1, input int s2, input int s3, input int s4);
    tab[i].name = nm; tab[i].op = op; tab[i].len = len;
    tab[i].st[0] = s0; tab[i].st[1] = s1; tab[i].st[2] = s2;
    tab[i].st[3] = s3; tab[i].st[4] = s4;
  endtask

  // Instruction-level model: state path of each instruction class.
  int m_path[5];
  int m_len;

  task automatic set_path(input logic [5:0] op);
    m_path = '{0, 1, 0, 0, 0};
    case (op)
      6'b000000: begin m_len = 4; m_path[2] = 6;  m_path[3] = 7;  end
      6'b100011: begin m_len = 5; m_path[2] = 2;  m_path[3] = 3;  m_path[4] = 4; end
      6'b101011: begin m_len = 4; m_path[2] = 2;  m_path[3] = 5;  end
      6'b000100: begin m_len = 3; m_path[2] = 8;  end
      6'b000010: begin m_len = 3; m_path[2] = 9;  end
      default:   begin m_len = 4; m_path[2] = 10; m_path[3] = 11; end
    endcase
  endtask

  int         lw_st[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
  logic       lw_rd[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
  logic [5:0] legal_ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                               6'b000010, 6'b001000};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  initial begin
    set_vec(0, "rtype", 6'b000000, 4, 0, 1, 6, 7, 0);
    set_vec(1, "lw",    6'b100011, 5, 0, 1, 2, 3, 4);
    set_vec(2, "sw",    6'b101011, 4, 0, 1, 2, 5, 0);
    set_vec(3, "beq",   6'b000100, 3, 0, 1, 8, 0, 0);
    set_vec(4, "j",     6'b000010, 3, 0, 1, 9, 0, 0);
    set_vec(5, "addi",  6'b001000, 4, 0, 1, 10, 11, 0);

    do_reset();

    // Zero-wait-state table: state path, outputs and latency.
    for (int v = 0; v < 6; v++) begin
      opcode = tab[v].op;
      zero = 1'($urandom);
      for (int c = 0; c < tab[v].len; c++) begin
        mem_ready = 1'b1;
        #1;
        chk_all(tab[v].name, tab[v].st[c], 1'b1, 1'b0, 1'b0);
        tick();
      end
      #1;
      chk1({tab[v].name, "_latency"}, 32'(state), 32'd0);
      $display("vector %s: opcode=%b cycles=%0d", tab[v].name, tab[v].op, tab[v].len);
    end

    // lw with three wait cycles in MEMRD.
    do_reset();
    opcode = 6'b100011;
    for (int c = 0; c < 9; c++) begin
      mem_ready = lw_rd[c];
      #1;
      chk_all("lw_wait", lw_st[c], lw_rd[c], 1'b0, 1'b0);
      tick();
    end
    $display("sequence lw_wait: 3 wait cycles in MEMRD");

    // Fetch timeout: 16 stalled cycles then ERROR.
    do_reset();
    for (int c = 0; c < MEM_TIMEOUT; c++) begin
      mem_ready = 1'b0;
      #1;
      chk_all("tmo_fetch", 0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    #1;
    chk_all("tmo_err", 13, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      mem_ready = 1'b1;
      #1;
      chk_all("tmo_hold", 13, 1'b1, 1'b1, 1'b0);
      tick();
    end
    $display("sequence timeout: ERROR after %0d fetch cycles", MEM_TIMEOUT);

    // Ready arriving on the last allowed cycle wins over the timeout.
    do_reset();
    for (int c = 0; c < MEM_TIMEOUT - 1; c++) begin
      mem_ready = 1'b0;
      #1;
      chk_all("tmo_edge_wait", 0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk_all("tmo_edge_ready", 0, 1'b1, 1'b0, 1'b0);
    tick();
    #1;
    chk_all("tmo_recover", 1, 1'b1, 1'b0, 1'b0);
    $display("sequence timeout_edge: ready on cycle %0d reaches DECODE", MEM_TIMEOUT);

    // Illegal opcode trap, held until reset.
    do_reset();
    opcode = 6'b010101;
    mem_ready = 1'b1;
    #1; chk_all("ill_fetch", 0, 1'b1, 1'b0, 1'b0); tick();
    #1; chk_all("ill_decode", 1, 1'b1, 1'b0, 1'b0); tick();
    for (int c = 0; c < 5; c++) begin
      mem_ready = 1'($urandom);
      #1;
      chk_all("ill_hold", 13, mem_ready, 1'b0, 1'b1);
      tick();
    end
    do_reset();
    $display("sequence illegal: opcode 010101 trapped, cleared by reset");

    // beq with zero both ways: same control outputs.
    for (int z = 0; z < 2; z++) begin
      do_reset();
      opcode = 6'b000100;
      zero = 1'(z);
      mem_ready = 1'b1;
      #1; chk_all("beq_fetch", 0, 1'b1, 1'b0, 1'b0); tick();
      #1; chk_all("beq_decode", 1, 1'b1, 1'b0, 1'b0); tick();
      #1; chk_all("beq_branch", 8, 1'b1, 1'b0, 1'b0); tick();
      #1; chk_all("beq_done", 0, 1'b1, 1'b0, 1'b0);
      $display("sequence beq: zero=%0d", z);
    end

    // HALT held over 50 cycles.
    do_reset();
    opcode = 6'b111111;
    mem_ready = 1'b1;
    #1; chk_all("halt_fetch", 0, 1'b1, 1'b0, 1'b0); tick();
    #1; chk_all("halt_decode", 1, 1'b1, 1'b0, 1'b0); tick();
    for (int c = 0; c < 50; c++) begin
      mem_ready = 1'($urandom);
      #1;
      chk_all("halt_hold", 12, mem_ready, 1'b0, 1'b0);
      tick();
    end
    $display("sequence halt: held 50 cycles");

    // Asynchronous reset in the middle of a stalled store.
    do_reset();
    opcode = 6'b101011;
    mem_ready = 1'b1;
    #1; chk_all("sw_fetch", 0, 1'b1, 1'b0, 1'b0); tick();
    #1; chk_all("sw_decode", 1, 1'b1, 1'b0, 1'b0); tick();
    #1; chk_all("sw_memadr", 2, 1'b1, 1'b0, 1'b0); tick();
    mem_ready = 1'b0;
    #1; chk_all("sw_wait", 5, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk1("async_mem_write", 32'(mem_write), 32'd0);
    chk1("async_state", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    $display("sequence async_reset: store abandoned mid-MEMWR");

    // Random mem_ready against the instruction-path model.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      logic [5:0] op;
      int pos, w, cyc;
      bit tmo;
      op = legal_ops[$urandom_range(0, 5)];
      set_path(op);
      opcode = op;
      zero = 1'($urandom);
      pos = 0; w = 0; cyc = 0; tmo = 0;
      while (pos < m_len && !tmo) begin
        int st;
        st = m_path[pos];
        mem_ready = ($urandom_range(0, 3) != 0);
        #1;
        chk_all("rnd", st, mem_ready, 1'b0, 1'b0);
        cyc++;
        if ((st == 0 || st == 3 || st == 5) && !mem_ready) begin
          if (w == MEM_TIMEOUT - 1) tmo = 1;
          else w++;
        end else begin
          pos++;
          w = 0;
        end
        tick();
      end
      if (tmo) begin
        #1;
        chk_all("rnd_timeout", 13, mem_ready, 1'b1, 1'b0);
        do_reset();
      end
      $display("random %0d: opcode=%b cycles=%0d timeout=%0d", i, op, cyc, tmo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
